// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Branch-resolution stage for the RV64 pipeline. It evaluates conditional
// branches, JAL and JALR, and computes the target, the link value and the
// correct next PC. It flags mispredictions against the front-end prediction.
// The block trains a bimodal table of 2-bit counters, and fetch can read that
// table through a combinational lookup port. There is one register stage,
// with valid/ready handshakes on the request side and on the result side.

// Protocol checks for the result interface. These are simulation-only
// observers and drive nothing.
module branch_resolve_unit_checker #(
  parameter int REG_WIDTH = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 in_ready,
  input logic                 out_valid,
  input logic                 out_ready,
  input logic                 out_taken,
  input logic                 out_mispredict,
  input logic                 out_illegal,
  input logic [REG_WIDTH-1:0] out_redirect_pc,
  input logic [REG_WIDTH-1:0] out_link
);

  // The unit may only accept when no result is waiting or the held result is leaving.
  a_ready_rule: assert property (@(posedge clk) disable iff (!rst_n)
    in_ready == (!out_valid || out_ready));

  // A result that is not consumed stays valid and unchanged.
  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_taken) &&
      $stable(out_mispredict) && $stable(out_illegal) &&
      $stable(out_redirect_pc) && $stable(out_link)));

  // An illegal request never resolves as taken.
  a_illegal_not_taken: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && out_illegal) |-> !out_taken);

endmodule

module branch_resolve_unit #(
  parameter int REG_WIDTH   = 64,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [2:0]           in_funct3,
  input  logic [REG_WIDTH-1:0] in_rs1,
  input  logic [REG_WIDTH-1:0] in_rs2,
  input  logic [REG_WIDTH-1:0] in_pc,
  input  logic [REG_WIDTH-1:0] in_imm,
  input  logic                 in_pred_taken,
  input  logic [REG_WIDTH-1:0] in_pred_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_taken,
  output logic                 out_mispredict,
  output logic                 out_illegal,
  output logic [REG_WIDTH-1:0] out_redirect_pc,
  output logic [REG_WIDTH-1:0] out_link,
  input  logic [REG_WIDTH-1:0] lookup_pc,
  output logic                 lookup_taken,
  output logic [CNT_WIDTH-1:0] stat_branches,
  output logic [CNT_WIDTH-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [1:0] OP_BRANCH = 2'd0;
  localparam logic [1:0] OP_JAL    = 2'd1;
  localparam logic [1:0] OP_JALR   = 2'd2;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_RSV2 = 3'd2;
  localparam logic [2:0] F3_RSV3 = 3'd3;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [REG_WIDTH-1:0] PC_STEP   = {{(REG_WIDTH-3){1'b0}}, 3'b100};
  localparam logic [REG_WIDTH-1:0] JALR_MASK = {{(REG_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [CNT_WIDTH-1:0] STAT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] STAT_MAX  = {CNT_WIDTH{1'b1}};

  // Counters come out of reset weakly not-taken.
  localparam logic [1:0] CNT_RESET = 2'b01;
  localparam logic [1:0] CNT_MAX   = 2'b11;
  localparam logic [1:0] CNT_MIN   = 2'b00;
  localparam logic [1:0] CNT_ONE   = 2'b01;

  // Request-side combinational results
  logic                 accept_s;
  logic                 cmp_taken_s;
  logic                 cmp_illegal_s;
  logic                 br_legal_s;
  logic                 taken_s;
  logic                 illegal_s;
  logic                 mispredict_s;
  logic [REG_WIDTH-1:0] link_s;
  logic [REG_WIDTH-1:0] br_target_s;
  logic [REG_WIDTH-1:0] jalr_target_s;
  logic [REG_WIDTH-1:0] target_s;
  logic [REG_WIDTH-1:0] redirect_s;

  // Branch history table
  logic [1:0]           bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0]     in_idx_s;
  logic [IDX_W-1:0]     lookup_idx_s;
  logic [1:0]           bht_cnt_s;
  logic [1:0]           bht_next_s;
  logic                 bht_we_s;

  // Result and statistics registers
  logic                 valid_q,      valid_d;
  logic                 taken_q,      taken_d;
  logic                 mispredict_q, mispredict_d;
  logic                 illegal_q,    illegal_d;
  logic [REG_WIDTH-1:0] redirect_q,   redirect_d;
  logic [REG_WIDTH-1:0] link_q,       link_d;
  logic [CNT_WIDTH-1:0] stat_br_q,    stat_br_d;
  logic [CNT_WIDTH-1:0] stat_mp_q,    stat_mp_d;

  // Lookup PC bits outside the index field do not select a counter.
  logic                 unused_s;

  assign in_ready      = !valid_q || out_ready;
  assign accept_s      = in_valid && in_ready;

  assign link_s        = in_pc + PC_STEP;
  assign br_target_s   = in_pc + in_imm;
  assign jalr_target_s = (in_rs1 + in_imm) & JALR_MASK;

  assign in_idx_s      = in_pc[IDX_W+1:2];
  assign lookup_idx_s  = lookup_pc[IDX_W+1:2];
  assign lookup_taken  = bht_q[lookup_idx_s][1];
  assign unused_s      = ^{lookup_pc[REG_WIDTH-1:IDX_W+2], lookup_pc[1:0]};

  // Evaluate the conditional-branch comparison selected by funct3.
  always_comb begin
    cmp_taken_s   = 1'b0;
    cmp_illegal_s = 1'b0;
    case (in_funct3)
      F3_BEQ:  cmp_taken_s = (in_rs1 == in_rs2);
      F3_BNE:  cmp_taken_s = (in_rs1 != in_rs2);
      F3_BLT:  cmp_taken_s = ($signed(in_rs1) <  $signed(in_rs2));
      F3_BGE:  cmp_taken_s = ($signed(in_rs1) >= $signed(in_rs2));
      F3_BLTU: cmp_taken_s = (in_rs1 <  in_rs2);
      F3_BGEU: cmp_taken_s = (in_rs1 >= in_rs2);
      F3_RSV2: cmp_illegal_s = 1'b1;
      F3_RSV3: cmp_illegal_s = 1'b1;
      default: begin
        cmp_taken_s   = 1'b0;
        cmp_illegal_s = 1'b1;
      end
    endcase
  end

  // Resolve the taken decision, the target and legality from the operation type.
  always_comb begin
    taken_s    = 1'b0;
    illegal_s  = 1'b0;
    target_s   = br_target_s;
    br_legal_s = 1'b0;
    case (in_op)
      OP_BRANCH: begin
        taken_s    = cmp_taken_s;
        illegal_s  = cmp_illegal_s;
        br_legal_s = !cmp_illegal_s;
      end
      OP_JAL: begin
        taken_s = 1'b1;
      end
      OP_JALR: begin
        taken_s  = 1'b1;
        target_s = jalr_target_s;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Compare the resolution against the prediction and pick the next PC.
  always_comb begin
    mispredict_s = 1'b0;
    redirect_s   = link_s;
    if (illegal_s) begin
      mispredict_s = in_pred_taken;
    end else begin
      mispredict_s = (taken_s != in_pred_taken) ||
                     (taken_s && (in_pred_target != target_s));
    end
    if (taken_s) begin
      redirect_s = target_s;
    end else begin
      redirect_s = link_s;
    end
  end

  // Next value of the addressed counter, saturating at both ends.
  always_comb begin
    bht_cnt_s  = bht_q[in_idx_s];
    bht_next_s = bht_cnt_s;
    bht_we_s   = accept_s && br_legal_s;
    if (cmp_taken_s) begin
      if (bht_cnt_s != CNT_MAX) begin
        bht_next_s = bht_cnt_s + CNT_ONE;
      end else begin
        bht_next_s = bht_cnt_s;
      end
    end else begin
      if (bht_cnt_s != CNT_MIN) begin
        bht_next_s = bht_cnt_s - CNT_ONE;
      end else begin
        bht_next_s = bht_cnt_s;
      end
    end
  end

  // Next state of the result stage. Load on accept, drain on consume, otherwise hold.
  always_comb begin
    valid_d      = valid_q;
    taken_d      = taken_q;
    mispredict_d = mispredict_q;
    illegal_d    = illegal_q;
    redirect_d   = redirect_q;
    link_d       = link_q;
    if (accept_s) begin
      valid_d      = 1'b1;
      taken_d      = taken_s;
      mispredict_d = mispredict_s;
      illegal_d    = illegal_s;
      redirect_d   = redirect_s;
      link_d       = link_s;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Next state of the saturating statistics counters.
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (accept_s && br_legal_s && (stat_br_q != STAT_MAX)) begin
      stat_br_d = stat_br_q + STAT_ONE;
    end else begin
      stat_br_d = stat_br_q;
    end
    if (accept_s && mispredict_s && (stat_mp_q != STAT_MAX)) begin
      stat_mp_d = stat_mp_q + STAT_ONE;
    end else begin
      stat_mp_d = stat_mp_q;
    end
  end

  // Result and statistics registers. Reset drops any held result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      redirect_q   <= {REG_WIDTH{1'b0}};
      link_q       <= {REG_WIDTH{1'b0}};
      stat_br_q    <= {CNT_WIDTH{1'b0}};
      stat_mp_q    <= {CNT_WIDTH{1'b0}};
    end else begin
      valid_q      <= valid_d;
      taken_q      <= taken_d;
      mispredict_q <= mispredict_d;
      illegal_q    <= illegal_d;
      redirect_q   <= redirect_d;
      link_q       <= link_d;
      stat_br_q    <= stat_br_d;
      stat_mp_q    <= stat_mp_d;
    end
  end

  // History table storage. Reset initialises every counter; legal conditional branches train it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CNT_RESET;
      end
    end else if (bht_we_s) begin
      bht_q[in_idx_s] <= bht_next_s;
    end
  end

  assign out_valid        = valid_q;
  assign out_taken        = taken_q;
  assign out_mispredict   = mispredict_q;
  assign out_illegal      = illegal_q;
  assign out_redirect_pc  = redirect_q;
  assign out_link         = link_q;
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

  branch_resolve_unit_checker #(
    .REG_WIDTH(REG_WIDTH)
  ) u_checker (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_ready       (in_ready),
    .out_valid      (valid_q),
    .out_ready      (out_ready),
    .out_taken      (taken_q),
    .out_mispredict (mispredict_q),
    .out_illegal    (illegal_q),
    .out_redirect_pc(redirect_q),
    .out_link       (link_q)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit. It uses directed vectors. A behavioural
// model is checked on every negative clock edge. Literal expectations are
// taken one time unit after the accept edge.
module tb_branch_resolve_unit;

  localparam int RW = 64;
  localparam int BE = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [1:0]    in_op;
  logic [2:0]    in_funct3;
  logic [RW-1:0] in_rs1, in_rs2, in_pc, in_imm, in_pred_target;
  logic          in_pred_taken;
  logic          out_valid, out_ready, out_taken, out_mispredict, out_illegal;
  logic [RW-1:0] out_redirect_pc, out_link, lookup_pc;
  logic          lookup_taken;
  logic [CW-1:0] stat_branches, stat_mispredicts;

  always #5 clk = ~clk;

  branch_resolve_unit #(.REG_WIDTH(RW), .BHT_ENTRIES(BE), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_mispredict(out_mispredict), .out_illegal(out_illegal),
    .out_redirect_pc(out_redirect_pc), .out_link(out_link), .lookup_pc(lookup_pc),
    .lookup_taken(lookup_taken), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        taken;
    logic        misp;
    logic        ill;
    logic [63:0] redir;
    logic [63:0] link;
  } res_t;

  function automatic res_t resolve(input logic [1:0] op, input logic [2:0] f3,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] pc, input logic [63:0] imm,
                                   input logic pt, input logic [63:0] ptgt);
    res_t r;
    logic [63:0] tgt;
    r = '0;
    r.link = pc + 64'd4;
    tgt = pc + imm;
    if (op == 2'd0) begin
      case (f3)
        3'd0: r.taken = (a == b);
        3'd1: r.taken = (a != b);
        3'd4: r.taken = ($signed(a) <  $signed(b));
        3'd5: r.taken = ($signed(a) >= $signed(b));
        3'd6: r.taken = (a <  b);
        3'd7: r.taken = (a >= b);
        default: r.ill = 1'b1;
      endcase
    end else if (op == 2'd1) begin
      r.taken = 1'b1;
    end else if (op == 2'd2) begin
      r.taken = 1'b1;
      tgt = (a + imm) & ~64'd1;
    end else begin
      r.ill = 1'b1;
    end
    r.redir = r.taken ? tgt : r.link;
    r.misp  = r.ill ? pt : ((r.taken != pt) || (r.taken && (ptgt != tgt)));
    return r;
  endfunction

  res_t        m_now, m_res;
  logic        m_valid;
  int          m_bht [BE];
  logic [31:0] m_br, m_mp;

  always_comb m_now = resolve(in_op, in_funct3, in_rs1, in_rs2, in_pc, in_imm,
                              in_pred_taken, in_pred_target);

  // Model state update on the active edge
  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_res   <= '0;
      m_br    <= 32'd0;
      m_mp    <= 32'd0;
      for (int i = 0; i < BE; i++) m_bht[i] <= 1;
    end else begin
      if (in_valid && (!m_valid || out_ready)) begin
        m_valid <= 1'b1;
        m_res   <= m_now;
        if (in_op == 2'd0 && !m_now.ill) begin
          if (m_now.taken) m_bht[int'((in_pc >> 2) % BE)] <=
              (m_bht[int'((in_pc >> 2) % BE)] == 3) ? 3 : m_bht[int'((in_pc >> 2) % BE)] + 1;
          else m_bht[int'((in_pc >> 2) % BE)] <=
              (m_bht[int'((in_pc >> 2) % BE)] == 0) ? 0 : m_bht[int'((in_pc >> 2) % BE)] - 1;
          if (m_br != 32'hFFFF_FFFF) m_br <= m_br + 32'd1;
        end
        if (m_now.misp && m_mp != 32'hFFFF_FFFF) m_mp <= m_mp + 32'd1;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Compare process, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid",      {63'd0, out_valid},      {63'd0, m_valid});
      chk("m_in_ready",   {63'd0, in_ready},       {63'd0, (!m_valid || out_ready)});
      chk("m_lookup",     {63'd0, lookup_taken},
          {63'd0, (m_bht[int'((lookup_pc >> 2) % BE)] >= 2)});
      chk("m_stat_br",    {32'd0, stat_branches},    {32'd0, m_br});
      chk("m_stat_mp",    {32'd0, stat_mispredicts}, {32'd0, m_mp});
      chk("m_taken",      {63'd0, out_taken},      {63'd0, m_res.taken});
      chk("m_mispredict", {63'd0, out_mispredict}, {63'd0, m_res.misp});
      chk("m_illegal",    {63'd0, out_illegal},    {63'd0, m_res.ill});
      chk("m_redirect",   out_redirect_pc,         m_res.redir);
      chk("m_link",       out_link,                m_res.link);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [1:0] op, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] pc, input logic [63:0] imm,
                       input logic pt, input logic [63:0] ptgt);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_funct3 = f3; in_rs1 = a; in_rs2 = b;
    in_pc = pc; in_imm = imm; in_pred_taken = pt; in_pred_target = ptgt;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; lookup_pc = 64'd0;
    in_op = 2'd0; in_funct3 = 3'd0; in_rs1 = 64'd0; in_rs2 = 64'd0; in_pc = 64'd0;
    in_imm = 64'd0; in_pred_taken = 1'b0; in_pred_target = 64'd0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_stat_br", {32'd0, stat_branches}, 64'd0);
    chk("rst_stat_mp", {32'd0, stat_mispredicts}, 64'd0);
    for (int i = 0; i < BE; i++) begin
      lookup_pc = 64'(i * 4);
      #1 chk("rst_lookup", {63'd0, lookup_taken}, 64'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) idle();
    chk("idle_valid", {63'd0, out_valid}, 64'd0);

    // blt: -1 < 1 signed -> taken; bltu: all-ones >= 1 -> not taken
    drive(2'd0, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h1000, 64'h40, 1'b0, 64'd0);
    idle();
    chk("blt_taken", {63'd0, out_taken}, 64'd1);
    chk("blt_misp", {63'd0, out_mispredict}, 64'd1);
    chk("blt_redir", out_redirect_pc, 64'h1040);
    chk("blt_link", out_link, 64'h1004);
    drive(2'd0, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h1000, 64'h40, 1'b0, 64'd0);
    idle();
    chk("bltu_taken", {63'd0, out_taken}, 64'd0);
    chk("bltu_misp", {63'd0, out_mispredict}, 64'd0);
    chk("bltu_redir", out_redirect_pc, 64'h1004);

    // JALR: target (0x2003 + 0x10) & ~1 = 0x2012
    drive(2'd2, 3'd0, 64'h2003, 64'd0, 64'h3000, 64'h10, 1'b1, 64'h2012);
    idle();
    chk("jalr_taken", {63'd0, out_taken}, 64'd1);
    chk("jalr_redir", out_redirect_pc, 64'h2012);
    chk("jalr_link", out_link, 64'h3004);
    chk("jalr_misp", {63'd0, out_mispredict}, 64'd0);
    drive(2'd2, 3'd0, 64'h2003, 64'd0, 64'h3000, 64'h10, 1'b1, 64'h2013);
    idle();
    chk("jalr_misp_tgt", {63'd0, out_mispredict}, 64'd1);

    // JAL wrapping at the top of the address space
    drive(2'd1, 3'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd8, 1'b1, 64'd4);
    idle();
    chk("jal_wrap_redir", out_redirect_pc, 64'd4);
    chk("jal_wrap_link", out_link, 64'd0);
    chk("jal_wrap_misp", {63'd0, out_mispredict}, 64'd0);

    // Training at pc 0x100 (index 0)
    lookup_pc = 64'h100;
    #1 chk("train_0", {63'd0, lookup_taken}, 64'd0);
    drive(2'd0, 3'd0, 64'd5, 64'd5, 64'h100, 64'h8, 1'b0, 64'd0); idle();
    chk("train_1", {63'd0, lookup_taken}, 64'd1);
    drive(2'd0, 3'd0, 64'd5, 64'd5, 64'h100, 64'h8, 1'b0, 64'd0); idle();
    drive(2'd0, 3'd0, 64'd5, 64'd5, 64'h100, 64'h8, 1'b0, 64'd0); idle();
    chk("train_3", {63'd0, lookup_taken}, 64'd1);
    drive(2'd0, 3'd0, 64'd5, 64'd6, 64'h100, 64'h8, 1'b0, 64'd0); idle();
    chk("untrain_1", {63'd0, lookup_taken}, 64'd1);
    drive(2'd0, 3'd0, 64'd5, 64'd6, 64'h100, 64'h8, 1'b0, 64'd0); idle();
    chk("untrain_2", {63'd0, lookup_taken}, 64'd0);
    lookup_pc = 64'h200;
    #1 chk("alias_read", {63'd0, lookup_taken}, 64'd0);
    drive(2'd0, 3'd0, 64'd5, 64'd5, 64'h200, 64'h8, 1'b0, 64'd0); idle();
    lookup_pc = 64'h100;
    #1 chk("alias_write", {63'd0, lookup_taken}, 64'd1);
    chk("stat_br_8", {32'd0, stat_branches}, 64'd8);
    chk("stat_mp_6", {32'd0, stat_mispredicts}, 64'd6);

    // Backpressure: A accepted, then B held off for four cycles
    drive(2'd0, 3'd1, 64'd1, 64'd2, 64'h800, 64'h20, 1'b1, 64'h820);
    out_ready = 1'b0;
    drive(2'd0, 3'd0, 64'd3, 64'd3, 64'h804, 64'h10, 1'b0, 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("stall_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_redir", out_redirect_pc, 64'h820);
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_stat", {32'd0, stat_branches}, 64'd9);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drive(2'd0, 3'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, 64'h808,
          64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h804);
    chk("b2b_B", out_redirect_pc, 64'h814);
    drive(2'd0, 3'd7, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h80C, 64'h40, 1'b0, 64'd0);
    chk("b2b_C", out_redirect_pc, 64'h804);
    chk("b2b_C_valid", {63'd0, out_valid}, 64'd1);
    idle();
    chk("b2b_D", out_redirect_pc, 64'h810);
    chk("b2b_D_taken", {63'd0, out_taken}, 64'd0);
    idle();
    chk("b2b_drain", {63'd0, out_valid}, 64'd0);
    chk("stat_br_12", {32'd0, stat_branches}, 64'd12);
    chk("stat_mp_7", {32'd0, stat_mispredicts}, 64'd7);

    // Illegal funct3 and reserved op
    drive(2'd0, 3'd2, 64'd0, 64'd0, 64'h100, 64'd0, 1'b1, 64'd0); idle();
    chk("ill_flag", {63'd0, out_illegal}, 64'd1);
    chk("ill_taken", {63'd0, out_taken}, 64'd0);
    chk("ill_misp", {63'd0, out_mispredict}, 64'd1);
    chk("ill_redir", out_redirect_pc, 64'h104);
    chk("ill_stat_br", {32'd0, stat_branches}, 64'd12);
    chk("ill_stat_mp", {32'd0, stat_mispredicts}, 64'd8);
    chk("ill_bht", {63'd0, lookup_taken}, 64'd1);
    drive(2'd3, 3'd0, 64'd0, 64'd0, 64'h100, 64'd0, 1'b0, 64'd0); idle();
    chk("op3_flag", {63'd0, out_illegal}, 64'd1);
    chk("op3_misp", {63'd0, out_mispredict}, 64'd0);

    // Reset while a result is held
    drive(2'd1, 3'd0, 64'd0, 64'd0, 64'h40, 64'h10, 1'b0, 64'd0);
    out_ready = 1'b0;
    idle();
    chk("hold_valid", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_drop_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_drop_stat", {32'd0, stat_mispredicts}, 64'd0);
    chk("rst_drop_bht", {63'd0, lookup_taken}, 64'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
